// File: rtl/mul16_seq_if.sv
// mul16_seq_if: request/result bundle for the sequential 16x16 multiplier.
// The master drives start and the operands. The slave returns busy, done and product.
interface mul16_seq_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add 16x16 multiplier that handles one multiplier bit per clock.
// A start sampled at edge N gives a one-cycle done pulse and a valid product after edge N+16.
// Optional feature: define MUL16_SEQ_SIGNED_EN for two's-complement operands.
// In that build the operands are reduced to magnitudes when they are latched.
// The sum is negated on the way into product when the operand signs differ.
module mul16_seq (
    input  logic         clock,
    input  logic         reset,
    mul16_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic        load;
    logic [31:0] mcand;     // multiplicand, shifted left once per RUN clock
    logic [15:0] mplier;    // multiplier, shifted right once per RUN clock
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic [31:0] sum;
    logic [15:0] mag_a, mag_b;
    logic        last;

`ifdef MUL16_SEQ_SIGNED_EN
    logic        neg;
    assign mag_a = bus.a[15] ? (~bus.a + 16'd1) : bus.a;
    assign mag_b = bus.b[15] ? (~bus.b + 16'd1) : bus.b;
`else
    assign mag_a = bus.a;
    assign mag_b = bus.b;
`endif

    // Partial-product add for the current LSB of the multiplier.
    assign sum  = acc + (mplier[0] ? mcand : 32'd0);
    assign last = (cnt == 5'd15);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic, status outputs and the operand-load strobe.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                // A start here begins the next operation with no idle gap.
                if (bus.start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch the operands on load, and do one shift-and-add step per RUN clock.
    // Product is written only on the final RUN clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            bus.product <= '0;
`ifdef MUL16_SEQ_SIGNED_EN
            neg         <= 1'b0;
`endif
        end else if (load) begin
            mcand  <= {16'd0, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
`ifdef MUL16_SEQ_SIGNED_EN
            neg    <= bus.a[15] ^ bus.b[15];
`endif
        end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (last) begin
`ifdef MUL16_SEQ_SIGNED_EN
                bus.product <= neg ? (~sum + 32'd1) : sum;
`else
                bus.product <= sum;
`endif
            end
        end
    end
endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request a multiply; sampled on the rising edge of clock.
REQ-004 a  input  16  multiplicand; sampled with start.
REQ-005 b  input  16  multiplier; sampled with start.
REQ-006 busy  output  1  high while an operation is in progress.
REQ-007 done  output  1  one-cycle pulse when product has been updated.
REQ-008 product  output  32  result of the last completed operation; holds its value between operations.

Function
REQ-009 FSM states SHALL be IDLE, RUN and DONE.
REQ-010 A start sampled in IDLE or DONE SHALL latch a and b, clear the 32-bit accumulator and the 5-bit bit counter, and enter RUN.
REQ-011 A start sampled in RUN SHALL be ignored; the latched operands SHALL NOT change.
REQ-012 RUN SHALL process one multiplier bit per clock, LSB first.
REQ-013 On each RUN clock, when the current multiplier bit is 1, the shifted multiplicand SHALL be added into the accumulator with carry preserved; when the bit is 0, the accumulator is unchanged.
REQ-014 After each RUN clock, the multiplicand SHALL shift left by 1 and the multiplier SHALL shift right by 1.
REQ-015 After exactly 16 RUN clocks, the FSM SHALL copy the accumulator to product and enter DONE.
REQ-016 If start is sampled at edge N, product SHALL be valid and done SHALL be 1 after edge N+16.
REQ-017 DONE SHALL last exactly one cycle and SHALL then go to IDLE, or to RUN if start is sampled, giving back-to-back operations with no idle gap.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-019 product SHALL keep the previous result throughout RUN and SHALL change only on the transition into DONE.
REQ-020 The result SHALL be exact modulo 2^32 with no overflow or truncation flag; a 16x16 product always fits in 32 bits.
REQ-021 Operands equal to 0 SHALL still take the full 16 RUN cycles; there is no early exit.

Reset
REQ-022 reset high SHALL immediately, without waiting for clock, force: state IDLE, busy 0, done 0, product 0x00000000, and the accumulator, counter and operand registers to 0.
REQ-023 reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow and product SHALL read 0.
REQ-024 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-025 The macro MUL16_SEQ_SIGNED_EN SHALL select the operand format.
REQ-026 With MUL16_SEQ_SIGNED_EN defined:
- a and b SHALL be treated as two's complement.
- Operands SHALL be converted to magnitudes at latch time.
- The product SHALL be negated when the operand signs differ, at the DONE transition.
- Latency SHALL be unchanged.
REQ-027 Without MUL16_SEQ_SIGNED_EN, a and b SHALL be treated as unsigned and no sign logic SHALL be synthesized.

Verification
REQ-028 After reset, start with a=0x0003, b=0x0005 -> busy 1 for 16 cycles, done pulses once, product=0x0000000F.
REQ-029 Unsigned build, a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; signed build, same operands -> product=0x00000001.
REQ-030 Signed build, a=0xFFFF (-1), b=0x0001 -> product=0xFFFFFFFF; a=0x8000, b=0x8000 -> product=0x40000000 in both builds.
REQ-031 start pulsed again mid-RUN with a=0x0002, b=0x0002 -> ignored; original result delivered; product unchanged until done.
REQ-032 start held high continuously with a=0x1234, b=0x0010 -> done pulses every 17 cycles, product=0x00012340 each time, busy low only during the DONE cycles.
REQ-033 reset asserted at RUN cycle 8 -> busy, done and product go to 0 immediately with no clock edge; no done pulse follows.
